custom_mult_csr: RTL and testbench



---
 rtl/custom_mult_csr_if.sv | 30 +++
 rtl/custom_mult_csr.sv | 187 ++++++++++++++++++
 tb/tb_custom_mult_csr.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/custom_mult_csr_if.sv
`default_nettype none
// ============================================================================
// Module   : custom_mult_csr_if
// Brief    : Wishbone-slave bus bundle for the multiplier control/status block.
// Revision : 1.0
// ============================================================================
interface custom_mult_csr_if #(
    parameter int BUS_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic [BUS_WIDTH-1:0]  adr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  we_i;
    logic [BE_WIDTH-1:0]   sel_i;
    logic                  stb_i;
    logic                  ack_o;

    modport master (
        output adr_i, data_i, we_i, sel_i, stb_i,
        input  data_o, ack_o
    );

    modport slave (
        input  adr_i, data_i, we_i, sel_i, stb_i,
        output data_o, ack_o
    );
endinterface
`default_nettype wire

// File: rtl/custom_mult_csr.sv
`default_nettype none
// ============================================================================
// Module   : custom_mult_csr
// Brief    : Wishbone CSR front-end that launches an N-bit multiplier core,
//            waits for completion with a timeout and captures the product.
// Revision : 1.0
// ============================================================================
module custom_mult_csr #(
    parameter int BUS_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int OP_WIDTH   = 4,
    parameter int TIMEOUT    = 64
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,
    custom_mult_csr_if.slave             wb,
    output logic [OP_WIDTH-1:0]          A_o,
    output logic [OP_WIDTH-1:0]          B_o,
    output logic                         start_o,
    input  wire logic [2*OP_WIDTH-1:0]   Y_i,
    input  wire logic                    fim_i,
    output logic                         busy_o,
    output logic                         irq_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OP_WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*OP_WIDTH-1:0]   result_q, result_d;
    logic                    irq_en_q, irq_en_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;
    logic                    to_q, to_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    irq_q, irq_d;

    logic                    accept, wr, rd, busy;
    logic                    ctrl_wr, start_req, clear_req;
    logic [DATA_WIDTH-1:0]   opnd_cur, opnd_new, rdata;
    logic                    unused_opnd_bits;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        to_d      = to_q;

        accept    = wb.stb_i & ~ack_q;
        wr        = accept & wb.we_i;
        rd        = accept & ~wb.we_i;
        busy      = (state_q != ST_IDLE);
        ack_d     = accept;

        opnd_cur                    = '0;
        opnd_cur[OP_WIDTH-1:0]      = a_q;
        opnd_cur[16 +: OP_WIDTH]    = b_q;
        opnd_new                    = opnd_cur;
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (wb.sel_i[k]) opnd_new[8*k +: 8] = wb.data_i[8*k +: 8];
        end

        ctrl_wr   = wr && (wb.adr_i == BUS_WIDTH'(0)) && wb.sel_i[0];
        start_req = ctrl_wr & wb.data_i[0];
        clear_req = ctrl_wr & wb.data_i[2];

        if (ctrl_wr) irq_en_d = wb.data_i[1];

        // Clear goes first so any event landing in the same cycle survives it.
        if (clear_req) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
            to_d   = 1'b0;
        end

        if (wr && (wb.adr_i == BUS_WIDTH'(1))) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else begin
                a_d = opnd_new[OP_WIDTH-1:0];
                b_d = opnd_new[16 +: OP_WIDTH];
            end
        end
        if (start_req && busy) ovr_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_req) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(1);
            end
            ST_WAIT: begin
                if (fim_i) begin
                    state_d  = ST_IDLE;
                    result_d = Y_i;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d  = ST_IDLE;
                    to_d     = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        rdata = '0;
        case (wb.adr_i)
            BUS_WIDTH'(0): rdata[1] = irq_en_q;
            BUS_WIDTH'(1): rdata = opnd_cur;
            BUS_WIDTH'(2): rdata[3:0] = {to_q, ovr_q, done_q, busy_q};
            default:       rdata[2*OP_WIDTH-1:0] = result_q;
        endcase
        data_d = rd ? rdata : '0;

        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
        irq_d   = done_d & irq_en_d;
    end

    assign unused_opnd_bits = ^opnd_new;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            to_q     <= 1'b0;
            ack_q    <= 1'b0;
            data_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            to_q     <= to_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            irq_q    <= irq_d;
        end
    end

    assign wb.ack_o  = ack_q;
    assign wb.data_o = data_q;
    assign A_o       = a_q;
    assign B_o       = b_q;
    assign start_o   = start_q;
    assign busy_o    = busy_q;
    assign irq_o     = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_custom_mult_csr.sv
`default_nettype none
// ============================================================================
// Module   : tb_custom_mult_csr
// Brief    : Directed scoreboard bench for custom_mult_csr (OP_WIDTH=4, TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_custom_mult_csr;
    localparam int OPW = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_i = 1'b0;
    logic [OPW-1:0] a_o, b_o;
    logic           start_o, busy_o, irq_o, fim_i;
    logic [2*OPW-1:0] y_i;

    int tests = 0;
    int fails = 0;
    int pend  = 0;
    int start_cnt = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] e;
    string       n;

    custom_mult_csr_if #(.BUS_WIDTH(2), .DATA_WIDTH(32), .BE_WIDTH(4)) wb ();

    custom_mult_csr #(
        .BUS_WIDTH(2), .DATA_WIDTH(32), .BE_WIDTH(4), .OP_WIDTH(OPW), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .wb(wb),
        .A_o(a_o), .B_o(b_o), .start_o(start_o),
        .Y_i(y_i), .fim_i(fim_i), .busy_o(busy_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response; writes expect zero read data.
    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (wb.ack_o) begin
            pend = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, wb.data_o, e);
            end
        end else if (rst_i) begin
            chk("idle_rdata", wb.data_o, 32'd0);
            if (exp_q.size() != 0) begin
                pend++;
                if (pend > 3) begin
                    n = name_q.pop_front();
                    e = exp_q.pop_front();
                    chk({n, "_ack_timeout"}, 32'd0, 32'd1);
                    pend = 0;
                end
            end
        end
    end

    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        wb.stb_i  = 1'b1;
        wb.we_i   = we;
        wb.adr_i  = adr;
        wb.data_i = dat;
        wb.sel_i  = sel;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk); #1;
        wb.stb_i  = 1'b0;
        wb.we_i   = 1'b0;
        wb.data_i = '0;
        wb.sel_i  = '0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus(1'b1, adr, dat, sel, 32'd0, "wr_ack");
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'd0, 4'h0, exp, name);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        int waits;
        wb.stb_i = 0; wb.we_i = 0; wb.adr_i = 0; wb.data_i = 0; wb.sel_i = 0;
        fim_i = 0; y_i = 0;
        repeat (2) cyc();
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_start", {31'd0, start_o}, 0);
        chk("rst_ack", {31'd0, wb.ack_o}, 0);
        chk("rst_irq", {31'd0, irq_o}, 0);
        rst_i = 1'b1;
        rd(2'd0, 32'h0, "rst_control");
        rd(2'd1, 32'h0, "rst_operands");
        rd(2'd2, 32'h0, "rst_status");
        rd(2'd3, 32'h0, "rst_result");

        // Basic multiply
        wr(2'd1, 32'h0007_0005, 4'hF);
        chk("basic_A", {28'd0, a_o}, 5);
        chk("basic_B", {28'd0, b_o}, 7);
        wr(2'd0, 32'h1, 4'h1);
        chk("basic_start_hi", {31'd0, start_o}, 1);
        chk("basic_busy_start", {31'd0, busy_o}, 1);
        cyc();
        chk("basic_start_lo", {31'd0, start_o}, 0);
        cyc();
        cyc();
        fim_i = 1; y_i = 8'h23;
        cyc();
        fim_i = 0; y_i = 0;
        chk("basic_busy_fall", {31'd0, busy_o}, 0);
        chk("basic_irq_off", {31'd0, irq_o}, 0);
        chk("basic_start_pulses", start_cnt, 1);
        rd(2'd2, 32'h2, "basic_status");
        rd(2'd3, 32'h23, "basic_result");
        rd(2'd1, 32'h0007_0005, "basic_operands");

        // Byte lanes
        wr(2'd1, 32'h000A_000B, 4'h1);
        wr(2'd1, 32'h000C_0000, 4'h4);
        rd(2'd1, 32'h000C_000B, "lanes_operands");

        // Overrun while in WAIT
        wr(2'd0, 32'h1, 4'h1);
        wr(2'd1, 32'h0001_0001, 4'hF);
        wr(2'd0, 32'h1, 4'h1);
        chk("ovr_busy", {31'd0, busy_o}, 1);
        chk("ovr_A", {28'd0, a_o}, 32'hB);
        chk("ovr_B", {28'd0, b_o}, 32'hC);
        fim_i = 1; y_i = 8'h84;
        cyc();
        fim_i = 0; y_i = 0;
        chk("ovr_start_pulses", start_cnt, 2);
        rd(2'd2, 32'h6, "ovr_status");
        rd(2'd3, 32'h84, "ovr_result");

        // Timeout
        wr(2'd0, 32'h4, 4'h1);
        rd(2'd2, 32'h0, "clear_status");
        wr(2'd0, 32'h1, 4'h1);
        waits = 0;
        while (busy_o && waits < 40) begin
            cyc();
            waits++;
        end
        chk("tmo_wait_cycles", waits - 1, TMO);
        rd(2'd2, 32'h8, "tmo_status");
        rd(2'd3, 32'h84, "tmo_result");

        // Interrupt and clear
        wr(2'd0, 32'h2, 4'h1);
        chk("irq_idle", {31'd0, irq_o}, 0);
        wr(2'd0, 32'h3, 4'h1);
        cyc();
        fim_i = 1; y_i = 8'h84;
        cyc();
        fim_i = 0; y_i = 0;
        chk("irq_set", {31'd0, irq_o}, 1);
        rd(2'd2, 32'hA, "irq_status");
        wr(2'd0, 32'h3, 4'h1);
        cyc();
        wb.stb_i = 1; wb.we_i = 1; wb.adr_i = 2'd0; wb.data_i = 32'h6; wb.sel_i = 4'h1;
        exp_q.push_back(32'd0);
        name_q.push_back("clr_fim_ack");
        fim_i = 1; y_i = 8'h84;
        cyc();
        wb.stb_i = 0; wb.we_i = 0; wb.data_i = 0; wb.sel_i = 0;
        fim_i = 0; y_i = 0;
        chk("clr_fim_irq", {31'd0, irq_o}, 1);
        rd(2'd2, 32'h2, "clr_fim_status");
        wr(2'd0, 32'h6, 4'h1);
        chk("clr_irq_low", {31'd0, irq_o}, 0);
        rd(2'd2, 32'h0, "clr_status");

        // Reset mid-operation
        wr(2'd0, 32'h3, 4'h1);
        cyc();
        fim_i = 1; y_i = 8'h84;
        cyc();
        fim_i = 0; y_i = 0;
        wr(2'd0, 32'h3, 4'h1);
        cyc();
        wb.stb_i = 1; wb.we_i = 0; wb.adr_i = 2'd2; wb.sel_i = 4'h0;
        cyc();
        wb.stb_i = 0;
        chk("prerst_ack", {31'd0, wb.ack_o}, 1);
        chk("prerst_busy", {31'd0, busy_o}, 1);
        chk("prerst_irq", {31'd0, irq_o}, 1);
        #1 rst_i = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_o}, 0);
        chk("midrst_start", {31'd0, start_o}, 0);
        chk("midrst_ack", {31'd0, wb.ack_o}, 0);
        chk("midrst_irq", {31'd0, irq_o}, 0);
        chk("midrst_data", wb.data_o, 0);
        chk("midrst_AB", {24'd0, a_o, b_o}, 0);
        repeat (2) cyc();
        rst_i = 1'b1;
        rd(2'd0, 32'h0, "postrst_control");
        rd(2'd1, 32'h0, "postrst_operands");
        rd(2'd2, 32'h0, "postrst_status");
        rd(2'd3, 32'h0, "postrst_result");
        repeat (6) cyc();
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
